// File: rtl/nibble_serial_sub.sv
// ============================================================================
// Module   : nibble_serial_sub
// Function : Serial A - B - bin, one 4-bit nibble per clock, LSB nibble first.
//            Optional signed overflow flag: define SUB_SIGNED_OVF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nibble_serial_sub #(
  parameter int WIDTH = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             bout,
  output logic             zero
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] c_last = CW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [CW+1:0]    w_idx;
  logic [3:0]       w_nib_a;
  logic [3:0]       w_nib_b;
  logic [4:0]       w_sum;
  logic [WIDTH-1:0] w_d_next;

  // Subtraction as addition of the complement; carry-in is the inverted borrow.
  always_comb begin
    w_idx    = {r_cnt, 2'b00};
    w_nib_a  = r_a[w_idx +: 4];
    w_nib_b  = r_b[w_idx +: 4];
    w_sum    = {1'b0, w_nib_a} + {1'b0, ~w_nib_b} + {4'b0000, r_carry};
    w_d_next = r_d;
    w_d_next[w_idx +: 4] = w_sum[3:0];
  end

  assign D = r_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_d       <= '0;
      r_carry   <= 1'b1;
      r_cnt     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      bout      <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= A;
            r_b      <= B;
            r_carry  <= ~bin;
            r_cnt    <= '0;
            r_d      <= '0;
            in_ready <= 1'b0;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_d     <= w_d_next;
          r_carry <= w_sum[4];
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == c_last) begin
            bout      <= ~w_sum[4];
            zero      <= (w_d_next == '0);
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SUB_SIGNED_OVF_EN
  // Overflow only possible when operand signs differ and the result sign flips away from A.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ovf <= 1'b0;
    end else if (r_state == S_CALC && r_cnt == c_last) begin
      ovf <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_d_next[WIDTH-1] != r_a[WIDTH-1]);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_sub.sv
// Scoreboard bench for nibble_serial_sub (WIDTH=16), random and directed operands.
`default_nettype none

module tb_nibble_serial_sub;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic              sys_clk   = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              in_valid  = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  A         = '0;
  logic [WIDTH-1:0]  B         = '0;
  logic              bin       = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  D;
  logic              bout;
  logic              zero;
`ifdef SUB_SIGNED_OVF_EN
  logic              ovf;
`endif

  nibble_serial_sub #(.WIDTH(WIDTH)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .bout      (bout),
    .zero      (zero)
`ifdef SUB_SIGNED_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             zero;
    logic             ovf;
    int               acc;
  } exp_t;

  exp_t sb[$];
  bit   rand_ready = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain wide unsigned arithmetic; the extra top bit is the borrow.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bi, input int acc);
    exp_t       e;
    logic [WIDTH:0] full;
    full   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bi};
    e.d    = full[WIDTH-1:0];
    e.bout = full[WIDTH];
    e.zero = (e.d == '0);
    e.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (e.d[WIDTH-1] != a[WIDTH-1]);
    e.acc  = acc;
    return e;
  endfunction

  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares on every output handshake, independent of the driver.
  bit               prev_ov = 1'b0;
  logic [WIDTH-1:0] prev_d  = '0;
  always @(negedge sys_clk) begin
    exp_t e;
    if (!sys_rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        check("ready_valid_exclusive", in_ready, 0);
        if (!prev_ov) begin
          if (sb.size() == 0) check("unexpected_out_valid", out_valid, 0);
          else check("latency", cyc - sb[0].acc, NIB);
        end else begin
          check("d_stable_in_done", D, prev_d);
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_result", out_valid, 0);
          end else begin
            e = sb.pop_front();
            check("D", D, e.d);
            check("bout", bout, e.bout);
            check("zero", zero, e.zero);
`ifdef SUB_SIGNED_OVF_EN
            check("ovf", ovf, e.ovf);
`endif
          end
        end
      end
      prev_ov = out_valid;
      prev_d  = D;
    end
  end

  // Accept one operation; with garbage=1 toggle junk on the inputs until back in IDLE.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic bi, input bit garbage);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      return;
    end
    in_valid = 1'b1;
    A        = a;
    B        = b;
    bin      = bi;
    sb.push_back(model(a, b, bi, cyc + 1));
    @(posedge sys_clk);
    #1;
    check("in_ready_low_after_accept", in_ready, 0);
    in_valid = 1'b0;
    if (garbage) begin
      n = 0;
      while (!in_ready && n < 200) begin
        in_valid = 1'($urandom_range(0, 1));
        A        = WIDTH'($urandom);
        B        = WIDTH'($urandom);
        bin      = 1'($urandom);
        @(posedge sys_clk);
        #1;
        n++;
      end
      in_valid = 1'b0;
      if (!in_ready) check("return_idle_timeout", in_ready, 1);
    end
  endtask

  initial begin
    int n;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_D", D, 0);
    check("rst_bout", bout, 0);
    check("rst_zero", zero, 0);
`ifdef SUB_SIGNED_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    send(16'h1234, 16'h0234, 1'b0, 1'b1);
    send(16'h0000, 16'h0001, 1'b0, 1'b1);
    send(16'h0000, 16'h0000, 1'b1, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 1'b1);

    // Backpressure: result must stay frozen while out_ready is low.
    rand_ready = 1'b0;
    @(posedge sys_clk);
    #1;
    out_ready = 1'b0;
    send(16'h5555, 16'h1111, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge sys_clk);
      #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_D", D, 16'h4444);
    end
    out_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    out_ready = 1'b0;
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);

    // Reset in the middle of CALC discards the operation.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    sys_rst_n = 1'b0;
    #1;
    sb.delete();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_D", D, 0);
    #2;
    sys_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge sys_clk);
      #1;
      check("postrst_no_valid", out_valid, 0);
    end
    check("postrst_in_ready", in_ready, 1);
    rand_ready = 1'b1;
    send(16'h0010, 16'h0001, 1'b0, 1'b1);
`ifdef SUB_SIGNED_OVF_EN
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b1);
`endif

    for (int t = 0; t < 150; t++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge sys_clk);
        #1;
      end
      ra = WIDTH'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? ra : WIDTH'($urandom);
      send(ra, rb, 1'($urandom), 1'b1);
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge sys_clk);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nibble_serial_sub.md
Name: nibble_serial_sub

Overview:
- Multi-cycle unsigned subtractor, the inverse-direction companion to the team's 4-bit CC4 carry-chain adder.
- Computes D = A - B - bin over WIDTH bits, one 4-bit nibble per clock, LSB nibble first.
- Each nibble is computed as A + ~B + carry, with carry = ~borrow.
- Sits between operand-producing logic and result consumers behind a valid/ready handshake on both sides.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, derived local parameter; nibble count and cycles in CALC.

Ports:
- sys_clk  input  1  single clock, rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands A, B, bin are valid.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- D  output  WIDTH  difference, A - B - bin mod 2^WIDTH.
- bout  output  1  borrow out; 1 iff A < B + bin (unsigned).
- zero  output  1  1 iff D == 0.

Behaviour:
- Reset (async assert, sync-style release on sys_clk):
  - state=IDLE, nibble counter=0, internal carry=1.
  - in_ready=1, out_valid=0, D=0, bout=0, zero=0.
  - Any in-flight operation is discarded.
- States and transitions:
  - IDLE→CALC on the edge where in_valid&in_ready. At that edge: latch A and B, set carry=~bin, counter=0, clear the D accumulator.
  - CALC: each edge computes nibble k = A[4k+3:4k] + ~B[4k+3:4k] + carry. Write the 4-bit sum into D[4k+3:4k], update carry to the nibble carry-out, k++. Leave CALC after the edge processing k=NIB-1.
  - CALC→DONE: on that last edge, bout=~carry_final, zero=(full D==0), out_valid=1.
  - DONE→IDLE on the edge where out_valid&out_ready.
- Handshake:
  - in_ready=1 only in IDLE (registered, from state).
  - out_valid=1 only in DONE.
  - D, bout, zero are stable for the whole of DONE and hold their last values in IDLE until the next result overwrites D during CALC.
  - in_valid is ignored outside IDLE.
  - A and B need only be valid on the accept edge.
- Latency: out_valid rises NIB cycles after the accept edge. Throughput is at most one result per NIB+2 cycles; no overlap of accept and result.
- Boundaries:
  - A==B with bin=0 → D=0, zero=1, bout=0.
  - bin=1 with A==B → D all ones, bout=1.
  - out_ready held low → DONE persists indefinitely with outputs frozen.
  - out_ready high while out_valid=0 → no effect.
  - Reset asserted mid-CALC or mid-DONE → immediate return to reset values; no partial result is ever presented.

Optional Feature:
- Macro SUB_SIGNED_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), valid with out_valid.
  - ovf=1 iff the two's-complement result overflows, i.e. sign(A)!=sign(B) and sign(D)!=sign(A).
  - Reset value 0; held with D.
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=16: A=0x1234, B=0x0234, bin=0 accepted at edge T → out_valid high after edge T+4 with D=0x1000, bout=0, zero=0; in_ready low from T+1 until return to IDLE.
- A=0x0000, B=0x0001, bin=0 → D=0xFFFF, bout=1, zero=0. Then A=0x0000, B=0x0000, bin=1 → D=0xFFFF, bout=1.
- A=0x8000, B=0x8000, bin=0 → D=0x0000, zero=1, bout=0. In parallel, toggle in_valid with garbage during CALC/DONE → no effect on the result.
- Result of 0x5555-0x1111 (D=0x4444) with out_ready held 0 for 10 cycles → out_valid and D stable. Assert out_ready for 1 cycle → out_valid drops and in_ready=1 the next cycle.
- Accept 0xFFFF-0x0001, then pulse sys_rst_n low at edge T+2 (mid-CALC) → out_valid never asserts, D=0, in_ready=1 after release. A following 0x0010-0x0001 gives D=0x000F.
- With SUB_SIGNED_OVF_EN defined:
  - A=0x8000, B=0x0001 → D=0x7FFF, ovf=1.
  - A=0x7FFF, B=0x0001 → D=0x7FFE, ovf=0.
